// File: rtl/imm_enc_pkg.sv
// Shared types and helpers for the rotate-immediate encoder.
// Holds the search FSM state encoding and the 32-bit rotate-left helper.
package imm_enc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    SEARCH_INV,
    DONE
  } state_t;

  localparam int ROT_STEPS = 16;

  function automatic logic [31:0] rol32(
    input logic [31:0] value,
    input logic [4:0]  amt
  );
    logic [63:0] dbl;
    dbl = {value, value} << amt;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/imm_rot_checker.sv
// Tests a window of consecutive rotations of one candidate.
// The lowest hitting rotation wins, giving the canonical encoding.
module imm_rot_checker
  import imm_enc_pkg::*;
#(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic [31:0] cand,
  input  logic [3:0]  base_rot,
  output logic        hit,
  output logic [3:0]  rot,
  output logic [7:0]  imm8
);

  logic [3:0]  r_i;
  logic [31:0] rv;

  // Walk downwards so the lowest rotation is assigned last.
  always_comb begin
    hit  = 1'b0;
    rot  = '0;
    imm8 = '0;
    r_i  = '0;
    rv   = '0;
    for (int i = CHECKS_PER_CYCLE - 1; i >= 0; i--) begin
      r_i = base_rot + 4'(i);
      rv  = rol32(cand, {r_i, 1'b0});
      if (rv[31:8] == 24'h0) begin
        hit  = 1'b1;
        rot  = r_i;
        imm8 = rv[7:0];
      end
    end
  end

endmodule

// File: rtl/imm_rot_encoder.sv
// Iterative search for a {rot,imm8} operand2 encoding of a constant.
// Optionally retries with the inverted value for MVN/BIC substitution.
module imm_rot_encoder
  import imm_enc_pkg::*;
#(
  parameter int DATA_LEN         = 32,
  parameter int CHECKS_PER_CYCLE = 1,
  parameter int ALLOW_INV        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                found,
  output logic                inverted,
  output logic [11:0]         offset
);

  localparam int STEPS = ROT_STEPS / CHECKS_PER_CYCLE;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t              state;
  logic [SW-1:0]       step;
  logic [DATA_LEN-1:0] cand;
  logic [3:0]          base_rot;
  logic                hit;
  logic [3:0]          hit_rot;
  logic [7:0]          hit_imm;
  logic                last_step;

  assign base_rot  = 4'(32'(step) * CHECKS_PER_CYCLE);
  assign last_step = (step == SW'(STEPS - 1));

  imm_rot_checker #(
    .CHECKS_PER_CYCLE(CHECKS_PER_CYCLE)
  ) u_checker (
    .cand    (cand),
    .base_rot(base_rot),
    .hit     (hit),
    .rot     (hit_rot),
    .imm8    (hit_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      found     <= 1'b0;
      inverted  <= 1'b0;
      offset    <= '0;
      step      <= '0;
      cand      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cand     <= in_value;
            step     <= '0;
            in_ready <= 1'b0;
            found    <= 1'b0;
            inverted <= 1'b0;
            offset   <= '0;
            state    <= SEARCH;
          end
        end
        SEARCH, SEARCH_INV: begin
          if (hit) begin
            found    <= 1'b1;
            offset   <= {hit_rot, hit_imm};
            inverted <= (state == SEARCH_INV);
            state    <= DONE;
          end else if (last_step) begin
            if (state == SEARCH && ALLOW_INV != 0) begin
              cand  <= ~cand;
              step  <= '0;
              state <= SEARCH_INV;
            end else begin
              found    <= 1'b0;
              inverted <= 1'b0;
              offset   <= '0;
              state    <= DONE;
            end
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          // Result registers settle one cycle before out_valid rises.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Scoreboarded bench for imm_rot_encoder across several configurations.
// Expected encodings and latencies come from an independent search model.
module tb_imm_rot_encoder;

  localparam int NI = 4;
  localparam int CPC_T [NI] = '{1, 1, 4, 16};
  localparam int INV_T [NI] = '{1, 0, 1, 1};

  typedef struct {
    logic        found;
    logic        inv;
    logic [11:0] off;
    int          lat;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [31:0] in_value  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        found     [NI];
  logic        inverted  [NI];
  logic [11:0] offset    [NI];

  int   n_checks;
  int   n_err;
  exp_t exp_q[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    imm_rot_encoder #(
      .DATA_LEN        (32),
      .CHECKS_PER_CYCLE(CPC_T[g]),
      .ALLOW_INV       (INV_T[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_value (in_value[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .found    (found[g]),
      .inverted (inverted[g]),
      .offset   (offset[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int a);
    int s;
    s = a % 32;
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic exp_t model(input logic [31:0] v, input int cpc,
                                 input int inv);
    exp_t        e;
    logic [31:0] t;
    logic [31:0] rl;
    logic [31:0] back;
    logic [7:0]  im;
    int          steps;
    e.found = 1'b0;
    e.inv   = 1'b0;
    e.off   = '0;
    e.val   = v;
    steps   = 0;
    for (int p = 0; p <= inv; p++) begin
      t = (p == 1) ? ~v : v;
      for (int r = 0; r < 16; r++) begin
        if (!e.found) begin
          rl   = ror32(t, 32 - 2 * r);
          im   = rl[7:0];
          back = ror32({24'h0, im}, 2 * r);
          if (back == t) begin
            e.found = 1'b1;
            e.inv   = (p == 1);
            e.off   = {4'(r), im};
            steps   = p * (16 / cpc) + r / cpc + 1;
          end
        end
      end
    end
    if (!e.found) steps = (inv + 1) * (16 / cpc);
    e.lat = steps + 1;
    return e;
  endfunction

  task automatic do_req(input int g, input logic [31:0] v, input int hold,
                        output logic [11:0] off_o);
    exp_t        e;
    int          lat;
    logic [31:0] dec;
    logic [11:0] off0;
    exp_q.push_back(model(v, CPC_T[g], INV_T[g]));
    off_o = '0;
    @(negedge clk);
    n_checks++;
    if (in_ready[g] !== 1'b1) begin
      n_err++;
      $display("FAIL ready_idle g%0d: got %b want 1", g, in_ready[g]);
    end
    in_value[g] = v;
    in_valid[g] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_value[g] = 32'hDEAD_BEEF;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid[g] === 1'b1) break;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid[g] !== 1'b1) begin
      n_err++;
      $display("FAIL timeout g%0d v=%h: no out_valid in %0d cycles", g, v, lat);
      return;
    end
    n_checks++;
    if (lat != e.lat) begin
      n_err++;
      $display("FAIL latency g%0d v=%h: got %0d want %0d", g, v, lat, e.lat);
    end
    n_checks++;
    if (found[g] !== e.found || inverted[g] !== e.inv || offset[g] !== e.off) begin
      n_err++;
      $display("FAIL result g%0d v=%h: got f=%b i=%b off=%h want f=%b i=%b off=%h",
               g, e.val, found[g], inverted[g], offset[g], e.found, e.inv, e.off);
    end
    if (e.found) begin
      off0 = offset[g];
      dec  = ror32({24'h0, off0[7:0]}, 2 * int'(off0[11:8]));
      n_checks++;
      if (dec !== (inverted[g] ? ~v : v)) begin
        n_err++;
        $display("FAIL val2 g%0d v=%h: decodes to %h", g, v, dec);
      end
    end
    off_o = offset[g];
    for (int k = 0; k < hold; k++) begin
      in_valid[g] = 1'b1;
      in_value[g] = 32'h0;
      out_ready[g] = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid[g] !== 1'b1 || in_ready[g] !== 1'b0 ||
          offset[g] !== e.off || found[g] !== e.found) begin
        n_err++;
        $display("FAIL hold g%0d cyc%0d: ov=%b ir=%b off=%h want ov=1 ir=0 off=%h",
                 g, k, out_valid[g], in_ready[g], offset[g], e.off);
      end
    end
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
    n_checks++;
    if (out_valid[g] !== 1'b0 || in_ready[g] !== 1'b1) begin
      n_err++;
      $display("FAIL release g%0d: ov=%b ir=%b want ov=0 ir=1",
               g, out_valid[g], in_ready[g]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      n_checks++;
      if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || found[g] !== 1'b0 ||
          inverted[g] !== 1'b0 || offset[g] !== 12'h000) begin
        n_err++;
        $display("FAIL reset g%0d: ir=%b ov=%b f=%b i=%b off=%h want 1 0 0 0 000",
                 g, in_ready[g], out_valid[g], found[g], inverted[g], offset[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [11:0] o;
    do_req(0, 32'h0000_0000, 0, o);
    do_req(0, 32'hFF00_0000, 0, o);
    n_checks++;
    if (o !== 12'h4FF) begin
      n_err++;
      $display("FAIL ff000000: got %h want 4ff", o);
    end
    do_req(0, 32'h0000_0104, 0, o);
    n_checks++;
    if (o !== 12'hF41) begin
      n_err++;
      $display("FAIL 00000104: got %h want f41", o);
    end
  endtask

  task automatic test_inverted();
    logic [11:0] o;
    do_req(0, 32'hFFFF_FFFF, 0, o);
    do_req(1, 32'hFFFF_FFFF, 0, o);
    do_req(0, 32'hFFFF_FF00, 0, o);
  endtask

  task automatic test_miss();
    logic [11:0] o;
    do_req(0, 32'h0000_0101, 0, o);
    do_req(1, 32'h0000_0101, 0, o);
    do_req(2, 32'h0000_0101, 0, o);
  endtask

  task automatic test_hold();
    logic [11:0] o;
    do_req(0, 32'h0003_FC00, 5, o);
  endtask

  task automatic test_reset_mid();
    logic [11:0] o;
    @(negedge clk);
    in_value[0] = 32'h0000_0101;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || offset[0] !== 12'h0) begin
      n_err++;
      $display("FAIL reset_mid: ov=%b ir=%b off=%h want 0 1 000",
               out_valid[0], in_ready[0], offset[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 32'h0000_03FC, 0, o);
  endtask

  task automatic test_cpc_sweep();
    logic [11:0] o0, o2, o3;
    logic [31:0] v;
    int          im, rt;
    for (int n = 0; n < 8; n++) begin
      im = $urandom_range(1, 255);
      rt = $urandom_range(0, 15);
      v  = ror32(32'(im), 2 * rt);
      do_req(0, v, 0, o0);
      do_req(2, v, 0, o2);
      do_req(3, v, 0, o3);
      n_checks++;
      if (o0 !== o2 || o0 !== o3) begin
        n_err++;
        $display("FAIL cpc_match v=%h: cpc1=%h cpc4=%h cpc16=%h", v, o0, o2, o3);
      end
    end
    do_req(3, 32'hFFFF_FFFF, 0, o3);
    do_req(3, 32'h0000_0101, 0, o3);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    for (int g = 0; g < NI; g++) begin
      in_valid[g]  = 1'b0;
      in_value[g]  = '0;
      out_ready[g] = 1'b0;
    end
    test_reset();
    test_direct();
    test_inverted();
    test_miss();
    test_hold();
    test_reset_mid();
    test_cpc_sweep();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
